// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern generator: mode encodings,
// FSM state encoding, LFSR tap mask and the rainbow hue helper.
package led_pattern_pkg;

    localparam logic [1:0] MODE_SOLID   = 2'd0;
    localparam logic [1:0] MODE_RAINBOW = 2'd1;
    localparam logic [1:0] MODE_RANDOM  = 2'd2;
    localparam logic [1:0] MODE_CHASE   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EMIT,
        ST_GAP,
        ST_FGAP
    } state_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Hue for rainbow mode; the product is deliberately truncated to 8 bits
    // so the hue wheel wraps naturally.
    function automatic logic [7:0] rainbow_hue(input logic [7:0] base,
                                               input logic [7:0] idx,
                                               input logic [7:0] step);
        logic [7:0] prod;
        prod = idx * step;
        return base + prod;
    endfunction

endpackage

// File: rtl/led_lfsr16.sv
// 16-bit Fibonacci LFSR, shifting left with feedback into bit 0.
// Advances only when step is high; exposes the low byte as the random hue.
module led_lfsr16
    import led_pattern_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    output logic [7:0] rnd
);

    logic [15:0] lfsr;

    // shift register, reloaded with the seed on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= SEED;
        end else if (step) begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign rnd = lfsr[7:0];

endmodule

// File: rtl/led_pattern_gen.sv
// HSV pattern source for the ws2812b driver path. Walks LED indices once per
// frame and emits one (led_num, h, s, v) record per LED under valid/ready.
// Optional build macro LED_PATTERN_BREATHE_EN adds a per-frame triangle
// brightness ramp that replaces every nonzero v.
//
// state   | meaning
// IDLE    | waiting for enable; latches mode/hue_in at frame start
// LOAD    | registers the record for the current index
// EMIT    | valid high, holding the record until ready
// GAP     | WRITE_DIV-cycle spacing between records
// FGAP    | FRAME_GAP-cycle idle after the last LED; frame_done on last cycle
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int          NUM_LEDS   = 50,
    parameter int          WRITE_DIV  = 16,
    parameter int          FRAME_GAP  = 1024,
    parameter int          HUE_STEP   = 5,
    parameter int          HUE_SPEED  = 1,
    parameter logic [7:0]  SATURATION = 8'hFF,
    parameter logic [7:0]  VALUE      = 8'd10,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic [7:0] hue_in,
    input  logic       ready,
    output logic       valid,
    output logic [7:0] led_num,
    output logic [7:0] h,
    output logic [7:0] s,
    output logic [7:0] v,
    output logic       frame_done
);

    localparam int               GAP_MAX   = (FRAME_GAP > WRITE_DIV) ? FRAME_GAP : WRITE_DIV;
    localparam int               CNT_W     = $clog2(GAP_MAX + 1);
    localparam logic [7:0]       LAST_IDX  = 8'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0] WDIV_LOAD = CNT_W'(WRITE_DIV - 1);
    localparam logic [CNT_W-1:0] FGAP_LOAD = CNT_W'(FRAME_GAP - 1);

    state_t           state, state_nxt;
    logic [7:0]       index;
    logic [1:0]       mode_q;
    logic [7:0]       hue_q;
    logic [7:0]       base_hue;
    logic [7:0]       chase_pos;
    logic [CNT_W-1:0] gap_cnt;
    logic [7:0]       rnd;
    logic [7:0]       h_calc;
    logic [7:0]       v_mode;
    logic [7:0]       v_calc;
    logic             accept;
    logic             gap_tc;
    logic             frame_end;

    assign accept    = (state == ST_EMIT) && ready;
    assign gap_tc    = (gap_cnt == '0);
    assign frame_end = (state == ST_FGAP) && gap_tc;

    led_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (accept && (mode_q == MODE_RANDOM)),
        .rnd   (rnd)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (enable) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_EMIT;
            ST_EMIT: if (ready) state_nxt = (index == LAST_IDX) ? ST_FGAP : ST_GAP;
            ST_GAP:  if (gap_tc) state_nxt = ST_LOAD;
            ST_FGAP: if (gap_tc) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        valid      = (state == ST_EMIT);
        frame_done = frame_end;
    end

    // index, latched frame settings, gap down-counter and per-frame animation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index     <= 8'd0;
            mode_q    <= MODE_SOLID;
            hue_q     <= 8'd0;
            gap_cnt   <= '0;
            base_hue  <= 8'd0;
            chase_pos <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        mode_q <= mode;
                        hue_q  <= hue_in;
                        index  <= 8'd0;
                    end
                end
                ST_EMIT: begin
                    if (ready) begin
                        if (index == LAST_IDX) begin
                            gap_cnt <= FGAP_LOAD;
                        end else begin
                            index   <= index + 8'd1;
                            gap_cnt <= WDIV_LOAD;
                        end
                    end
                end
                ST_GAP: begin
                    if (!gap_tc) gap_cnt <= gap_cnt - CNT_W'(1);
                end
                ST_FGAP: begin
                    if (!gap_tc) begin
                        gap_cnt <= gap_cnt - CNT_W'(1);
                    end else begin
                        base_hue  <= base_hue + 8'(HUE_SPEED);
                        chase_pos <= (chase_pos == LAST_IDX) ? 8'd0 : chase_pos + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // per-mode hue and value for the record being loaded
    always_comb begin
        h_calc = hue_q;
        v_mode = VALUE;
        case (mode_q)
            MODE_SOLID:   h_calc = hue_q;
            MODE_RAINBOW: h_calc = rainbow_hue(base_hue, index, 8'(HUE_STEP));
            MODE_RANDOM:  h_calc = rnd;
            default: begin
                h_calc = base_hue;
                v_mode = (index == chase_pos) ? VALUE : 8'd0;
            end
        endcase
    end

`ifdef LED_PATTERN_BREATHE_EN
    logic [7:0] level;
    logic       level_up;

    // triangle brightness ramp 0..VALUE..0, one step per completed frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level    <= 8'd0;
            level_up <= 1'b1;
        end else if (frame_end && (VALUE != 8'd0)) begin
            if (level_up) begin
                if (level == VALUE) begin
                    level_up <= 1'b0;
                    level    <= level - 8'd1;
                end else begin
                    level <= level + 8'd1;
                end
            end else begin
                if (level == 8'd0) begin
                    level_up <= 1'b1;
                    level    <= level + 8'd1;
                end else begin
                    level <= level - 8'd1;
                end
            end
        end
    end

    assign v_calc = (v_mode != 8'd0) ? level : 8'd0;
`else
    assign v_calc = v_mode;
`endif

    // record registers, captured in LOAD and held through EMIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_num <= 8'd0;
            h       <= 8'd0;
            s       <= 8'd0;
            v       <= 8'd0;
        end else if (state == ST_LOAD) begin
            led_num <= index;
            h       <= h_calc;
            s       <= SATURATION;
            v       <= v_calc;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with a record scoreboard.
module tb_led_pattern_gen;
    import led_pattern_pkg::*;

    localparam int          NL   = 4;
    localparam int          WD   = 2;
    localparam int          FG   = 6;
    localparam int          HS   = 5;
    localparam int          HSP  = 1;
    localparam logic [7:0]  SAT  = 8'hFF;
    localparam logic [7:0]  VAL  = 8'h0A;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct packed {
        logic [7:0] led;
        logic [7:0] h;
        logic [7:0] s;
        logic [7:0] v;
    } rec_t;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [1:0] mode;
    logic [7:0] hue_in;
    logic       ready;
    logic       valid;
    logic [7:0] led_num;
    logic [7:0] h;
    logic [7:0] s;
    logic [7:0] v;
    logic       frame_done;

    rec_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [7:0]  m_base = 8'd0;
    logic [7:0]  m_chase = 8'd0;
    logic [15:0] m_lfsr = SEED;

    int          last_acc = 0;
    int          last_frame_acc = 0;
    bit          in_frame = 0;
    bit          prev_valid = 0;

    led_pattern_gen #(
        .NUM_LEDS   (NL),
        .WRITE_DIV  (WD),
        .FRAME_GAP  (FG),
        .HUE_STEP   (HS),
        .HUE_SPEED  (HSP),
        .SATURATION (SAT),
        .VALUE      (VAL),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .hue_in     (hue_in),
        .ready      (ready),
        .valid      (valid),
        .led_num    (led_num),
        .h          (h),
        .s          (s),
        .v          (v),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    task automatic push_frame(input logic [1:0] md, input logic [7:0] hue);
        rec_t r;
        for (int i = 0; i < NL; i++) begin
            r.led = 8'(i);
            r.s   = SAT;
            r.v   = VAL;
            case (md)
                MODE_SOLID:   r.h = hue;
                MODE_RAINBOW: r.h = m_base + 8'(i * HS);
                MODE_RANDOM: begin
                    r.h    = m_lfsr[7:0];
                    m_lfsr = lfsr_next(m_lfsr);
                end
                default: begin
                    r.h = m_base;
                    r.v = (8'(i) == m_chase) ? VAL : 8'h00;
                end
            endcase
            exp_q.push_back(r);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_base  = 8'd0;
        m_chase = 8'd0;
        m_lfsr  = SEED;
    endtask

    // Scoreboard monitor: compares every presented record with the queue
    // head, pops on handshake, and checks record/frame spacing.
    always @(negedge clk) begin
        rec_t hd;
        if (reset) begin
            in_frame   = 0;
            prev_valid = 0;
        end else begin
            if (valid) begin
                n_vec++;
                assert (exp_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_record: observed led %0d with empty queue expected none", led_num);
                end
                if (exp_q.size() != 0) begin
                    hd = exp_q[0];
                    check8("led_num", led_num, hd.led);
                    check8("h", h, hd.h);
                    check8("s", s, hd.s);
                    check8("v", v, hd.v);
                    if (ready) void'(exp_q.pop_front());
                end
                if (!prev_valid && in_frame) check_int("record_spacing", cyc - last_acc, WD + 2);
                if (ready) begin
                    last_acc = cyc;
                    in_frame = (led_num != 8'(NL - 1));
                    if (led_num == 8'(NL - 1)) last_frame_acc = cyc;
                end
            end
            if (frame_done) check_int("frame_gap", cyc - last_frame_acc, FG);
            prev_valid = valid;
        end
    end

    task automatic wait_valid(input string tag, output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                ok = 1;
                break;
            end
        end
        n_vec++;
        assert (ok) else begin
            n_err++;
            $error("FAIL %s: observed no valid within 200 cycles expected valid", tag);
        end
    endtask

    task automatic run_frame(input logic [1:0] md, input logic [7:0] hue,
                             input bit switch_mid, input bit stall);
        bit ok;
        bit seen;
        push_frame(md, hue);
        mode   = md;
        hue_in = hue;
        enable = 1'b1;
        wait_valid("frame_start", ok);
        enable = 1'b0;
        if (switch_mid) begin
            mode   = MODE_RAINBOW;
            hue_in = 8'h99;
        end
        if (stall) begin
            seen = 0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(posedge clk);
                #1;
                if (valid && led_num == 8'd2) seen = 1;
            end
            check_int("stall_reach_led2", int'(seen), 1);
            ready = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(posedge clk);
                #1;
                check8("stall_valid_held", {7'd0, valid}, 8'h01);
            end
            ready = 1'b1;
        end
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1;
        end
        check_int("frame_done_seen", int'(seen), 1);
        m_base  = m_base + 8'(HSP);
        m_chase = (m_chase == 8'(NL - 1)) ? 8'd0 : m_chase + 8'd1;
        check_int("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        bit ok;
        reset  = 1'b1;
        enable = 1'b0;
        mode   = MODE_SOLID;
        hue_in = 8'h00;
        ready  = 1'b1;
        #1;
        check8("rst_valid", {7'd0, valid}, 8'h00);
        check8("rst_led_num", led_num, 8'h00);
        check8("rst_h", h, 8'h00);
        check8("rst_s", s, 8'h00);
        check8("rst_v", v, 8'h00);
        check8("rst_frame_done", {7'd0, frame_done}, 8'h00);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // rainbow from base 0: 00,05,0A,0F then 01,06,0B,10
        run_frame(MODE_RAINBOW, 8'h00, 0, 0);
        run_frame(MODE_RAINBOW, 8'h00, 0, 0);
        // solid hue 40
        run_frame(MODE_SOLID, 8'h40, 0, 0);
        // mode switched mid-frame: remainder stays solid, next frame rainbow
        run_frame(MODE_SOLID, 8'h22, 1, 0);
        run_frame(MODE_RAINBOW, 8'h00, 0, 0);
        // ready held low for 100 cycles at led 2
        run_frame(MODE_SOLID, 8'h77, 0, 1);

        // async reset while a record is presented
        mode   = MODE_SOLID;
        hue_in = 8'h55;
        enable = 1'b1;
        wait_valid("reset_frame_start", ok);
        enable = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check8("midreset_valid", {7'd0, valid}, 8'h00);
        check8("midreset_led_num", led_num, 8'h00);
        check8("midreset_h", h, 8'h00);
        check8("midreset_s", s, 8'h00);
        check8("midreset_v", v, 8'h00);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // chase across a wrap of chase_pos
        for (int f = 0; f < 5; f++) run_frame(MODE_CHASE, 8'h00, 0, 0);

        // random from the seed, 300 records
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        reset = 1'b0;
        @(negedge clk);
        for (int f = 0; f < 75; f++) run_frame(MODE_RANDOM, 8'h00, 0, 0);

        // long rainbow run so base_hue and the hue sum wrap past 255
        for (int f = 0; f < 200; f++) run_frame(MODE_RAINBOW, 8'h00, 0, 0);

        repeat (5) @(negedge clk);
        check_int("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised HSV pattern source feeding the ws2812b driver through the hsv_to_rgb converter; replaces the fixed per-tick colour write logic in top-level designs.
- Walks LED index 0..NUM_LEDS-1 once per frame and emits one (led_num, H, S, V) record per LED under a valid/ready handshake.
- Supports four run-time modes: solid, rainbow, random (LFSR) and chase. Inter-LED spacing, frame gap and per-frame animation step are configurable.

Parameters:
- NUM_LEDS, 50: LEDs per frame, range 1..255.
- WRITE_DIV, 16: minimum clocks from one accepted record to the next LOAD, must be at least 1.
- FRAME_GAP, 1024: idle clocks after the last LED of a frame, must be at least 1.
- HUE_STEP, 5: rainbow hue increment per LED index.
- HUE_SPEED, 1: rainbow base-hue increment per frame.
- SATURATION, 8'hFF: S value for every record.
- VALUE, 8'd10: V value for lit LEDs.
- LFSR_SEED, 16'hACE1: random-mode seed, must be non-zero.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run frames while high; sampled only in IDLE.
- mode  in  2  0 solid, 1 rainbow, 2 random, 3 chase; latched at frame start.
- hue_in  in  8  hue used in solid mode; latched at frame start.
- ready  in  1  driver can accept a record.
- valid  out  1  record on led_num/h/s/v is valid (maps to the driver's write).
- led_num  out  8  LED index of the current record.
- h  out  8  hue.
- s  out  8  saturation.
- v  out  8  value.
- frame_done  out  1  one-cycle pulse when a frame's gap completes.

Behaviour:
- Reset: all outputs are 0. State is IDLE, index 0, base_hue 0, chase_pos 0, LFSR set to LFSR_SEED.
- FSM states: IDLE, LOAD, EMIT, GAP, FGAP.
- IDLE: if enable, latch mode and hue_in, set index 0, go to LOAD. Otherwise stay; valid is 0.
- LOAD (1 cycle): register led_num=index, s=SATURATION, and h/v computed per the latched mode. Next state EMIT. Latency from IDLE exit to valid is 2 cycles.
- EMIT: valid=1. Outputs are held stable until ready is high. On valid&&ready, valid drops the next cycle.
  - If index==NUM_LEDS-1, go to FGAP.
  - Otherwise increment index and go to GAP.
- GAP: wait WRITE_DIV cycles, then go to LOAD.
- FGAP: wait FRAME_GAP cycles. On the last cycle:
  - pulse frame_done;
  - base_hue += HUE_SPEED (mod 256);
  - chase_pos advances and wraps from NUM_LEDS-1 to 0;
  - go to IDLE. IDLE re-enters LOAD on the next cycle if enable is still high.
- Mode outputs:
  - Solid: h=hue_in_latched, v=VALUE.
  - Rainbow: h=(base_hue + index*HUE_STEP) mod 256, computed as an 8-bit truncated product; v=VALUE.
  - Random: h=lfsr[7:0], v=VALUE. The LFSR advances once per accepted record. It is a 16-bit Fibonacci LFSR with taps 16,14,13,11 that shifts left with feedback into bit 0.
  - Chase: h=base_hue, v=VALUE when index==chase_pos, else 0.
- Boundaries:
  - ready may be held low indefinitely; no record is dropped or altered.
  - enable low mid-frame has no effect; the frame completes.
  - A mode change mid-frame takes effect at the next frame.
  - NUM_LEDS=1: EMIT goes directly to FGAP.
  - Asynchronous reset mid-frame returns to IDLE immediately with valid=0.

Optional Feature:
- Macro: LED_PATTERN_BREATHE_EN.
- With the macro defined: an 8-bit brightness level ramps 0→VALUE→0, moving by 1 per frame (triangle wave, direction flips at each end). Every nonzero v is replaced by the current level. The level resets to 0 counting upward.
- Without the macro: v is exactly as specified per mode.

Decomposition:
- Package led_pattern_pkg holds:
  - mode encoding constants MODE_SOLID, MODE_RAINBOW, MODE_RANDOM, MODE_CHASE;
  - the FSM state encoding;
  - LFSR tap mask.
- One sub-module, led_lfsr16: the enabled 16-bit LFSR with seed parameter and step input.
- The counters and FSM stay in led_pattern_gen.

Test Plan:
- Solid, ready tied high, NUM_LEDS=4, WRITE_DIV=2, hue_in=8'h40 → 4 valid pulses, led_num 0,1,2,3, h=40, s=FF, v=0A, then frame_done after FRAME_GAP.
- Rainbow, HUE_STEP=5, HUE_SPEED=1 → frame 0 h=00,05,0A,0F; frame 1 h=01,06,0B,10. With NUM_LEDS=60, index 52 gives h=04 (wrap).
- Random with default seed → first h=E1 (LFSR low byte); second h equals low byte of the next LFSR state. Sequence matches a golden model for 300 records.
- Chase, NUM_LEDS=3 → frame 0 v=0A,0,0; frame 1 v=0,0A,0; frame 3 wraps to v=0A,0,0.
- Ready low for 100 cycles during led_num=2 → valid stays high, outputs stable, next record only after ready. Assert reset during EMIT → valid=0 and all outputs 0 asynchronously.
- Mode switched from 0 to 1 mid-frame → remainder of that frame stays solid; rainbow starts at the next frame's led_num 0.
